// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline memory-access stage.
//   mem_state_t : control FSM states of mem_stage
//   SZ_*        : encodings of the mem_size field (2'b11 is reserved and is
//                 handled like a word access)
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,  // can accept an instruction
    REQ  = 2'b01,  // memory request outstanding
    HOLD = 2'b10   // writeback record waiting for out_ready
  } mem_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for big-endian byte/half/word accesses.
//   addr_lo    : address bits [1:0]
//   size       : access size (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 acts as word)
//   is_signed  : sign-extend the loaded lane
//   store_data : raw store operand
//   rdata      : raw memory read word
//   be         : byte enables, bit 3 covers [31:24]
//   wdata      : store data replicated across the lanes
//   load_data  : selected lane, zero/sign extended to 32 bits
//   misalign   : half at odd address or word at non-multiple-of-4 address
module lsu_align
  import mips_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    misalign  = 1'b0;
    lane8     = 8'h00;
    lane16    = 16'h0000;
    case (size)
      SZ_BYTE: begin
        // Offset 0 is the most significant byte.
        be    = 4'b1000 >> addr_lo;
        wdata = {4{store_data[7:0]}};
        case (addr_lo)
          2'd0:    lane8 = rdata[31:24];
          2'd1:    lane8 = rdata[23:16];
          2'd2:    lane8 = rdata[15:8];
          default: lane8 = rdata[7:0];
        endcase
        load_data = is_signed ? {{24{lane8[7]}}, lane8} : {24'h000000, lane8};
      end
      SZ_HALF: begin
        be       = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata    = {2{store_data[15:0]}};
        lane16   = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        load_data = is_signed ? {{16{lane16[15]}}, lane16} : {16'h0000, lane16};
        misalign = addr_lo[0];
      end
      default: begin
        misalign = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS pipeline memory-access stage.
// Takes the ALU result as effective address and rt as store data, runs a
// load/store over a request/acknowledge data-memory port and presents a
// registered writeback record. Non-memory instructions pass through with one
// cycle of latency.
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : handshake from the execute stage
//   alu_result, rt           : address (or pass-through value), store data
//   mem_read/mem_write       : load/store (both high is treated as a store)
//   mem_size, mem_signed     : access size, sign-extend on load
//   reg_write, wb_reg_in     : register write enable and destination
//   dmem_*                   : data memory port (ack with same-cycle rdata)
//   out_valid/out_ready      : handshake to the writeback stage
//   wb_data, wb_reg, wb_en   : writeback record
//   exc_misalign             : misaligned access flag, qualified by out_valid
module mem_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] rt,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic        reg_write,
  input  logic [4:0]  wb_reg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_en,
  output logic        exc_misalign
);

  mem_state_t  state_reg, state_next;

  // Instruction fields latched at accept, used when the ack arrives.
  logic [1:0]  off_reg;
  logic [1:0]  size_reg;
  logic        signed_reg;
  logic        store_reg;
  logic        reg_write_reg;
  logic [4:0]  dest_reg;

  logic        accept;
  logic        is_mem;
  logic        in_req;
  logic [1:0]  al_off;
  logic [1:0]  al_size;
  logic        al_signed;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_misalign;

  assign in_ready = !rst && (state_reg == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mem   = mem_read || mem_write;
  assign in_req   = (state_reg == REQ);

  // One aligner serves both phases: in IDLE it sees the incoming instruction
  // (enables, store data, misalign); in REQ it sees the latched fields so the
  // returning read data is extracted with the original size and offset.
  assign al_off    = in_req ? off_reg    : alu_result[1:0];
  assign al_size   = in_req ? size_reg   : mem_size;
  assign al_signed = in_req ? signed_reg : mem_signed;

  lsu_align u_align (
    .addr_lo    (al_off),
    .size       (al_size),
    .is_signed  (al_signed),
    .store_data (rt),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misalign   (al_misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && is_mem && !al_misalign)
          state_next = REQ;
        else if (!accept && out_valid && !out_ready)
          // Pass-through record not drained: park until out_ready.
          state_next = HOLD;
      end
      REQ:  if (dmem_ack)  state_next = HOLD;
      HOLD: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'h0;
      dmem_wdata    <= 32'h0;
      dmem_be       <= 4'h0;
      out_valid     <= 1'b0;
      wb_data       <= 32'h0;
      wb_reg        <= 5'd0;
      wb_en         <= 1'b0;
      exc_misalign  <= 1'b0;
      off_reg       <= 2'b00;
      size_reg      <= SZ_BYTE;
      signed_reg    <= 1'b0;
      store_reg     <= 1'b0;
      reg_write_reg <= 1'b0;
      dest_reg      <= 5'd0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (accept) begin
        off_reg       <= alu_result[1:0];
        size_reg      <= mem_size;
        signed_reg    <= mem_signed;
        store_reg     <= mem_write;
        reg_write_reg <= reg_write;
        dest_reg      <= wb_reg_in;
        if (is_mem && !al_misalign) begin
          dmem_req   <= 1'b1;
          dmem_we    <= mem_write;
          dmem_addr  <= {alu_result[31:2], 2'b00};
          dmem_wdata <= al_wdata;
          dmem_be    <= al_be;
        end else begin
          // Pass-through or misaligned access: record ready next cycle.
          out_valid    <= 1'b1;
          wb_data      <= alu_result;
          wb_reg       <= wb_reg_in;
          wb_en        <= reg_write && !is_mem;
          exc_misalign <= is_mem;
        end
      end

      if (in_req && dmem_ack) begin
        dmem_req     <= 1'b0;
        dmem_we      <= 1'b0;
        dmem_be      <= 4'h0;
        out_valid    <= 1'b1;
        wb_reg       <= dest_reg;
        exc_misalign <= 1'b0;
        if (store_reg) begin
          wb_en <= 1'b0;
        end else begin
          wb_data <= al_load;
          wb_en   <= reg_write_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] rt;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic        reg_write;
  logic [4:0]  wb_reg_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_en;
  logic        exc_misalign;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .rt(rt), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_signed(mem_signed), .reg_write(reg_write),
    .wb_reg_in(wb_reg_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .wb_data(wb_data), .wb_reg(wb_reg), .wb_en(wb_en),
    .exc_misalign(exc_misalign)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rtv;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic        rw;
    logic [4:0]  rg;
    logic [31:0] rdata;
    int          delay;      // request cycles without ack before the ack cycle
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
    logic        exp_en;
    logic        exp_exc;
    logic        chk_wb;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] r, input logic rd,
                       input logic wr, input logic [1:0] sz, input logic sg,
                       input logic rw, input logic [4:0] rg);
    alu_result = a; rt = r; mem_read = rd; mem_write = wr;
    mem_size = sz; mem_signed = sg; reg_write = rw; wb_reg_in = rg;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    drive(v.alu, v.rtv, v.rd, v.wr, v.sz, v.sg, v.rw, v.rg);
    in_valid = 1'b1;
    chk($sformatf("v%0d in_ready", idx), {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    if (v.exp_req) begin
      chk($sformatf("v%0d dmem_req", idx), {31'b0, dmem_req}, 32'd1);
      chk($sformatf("v%0d dmem_addr", idx), dmem_addr, v.exp_addr);
      chk($sformatf("v%0d dmem_be", idx), {28'b0, dmem_be}, {28'b0, v.exp_be});
      chk($sformatf("v%0d dmem_we", idx), {31'b0, dmem_we}, {31'b0, v.exp_we});
      if (v.exp_we) chk($sformatf("v%0d dmem_wdata", idx), dmem_wdata, v.exp_wdata);
      chk($sformatf("v%0d out_valid early", idx), {31'b0, out_valid}, 32'd0);
      for (int i = 0; i < v.delay; i++) begin
        tick();
        chk($sformatf("v%0d req held", idx), {31'b0, dmem_req}, 32'd1);
        chk($sformatf("v%0d addr held", idx), dmem_addr, v.exp_addr);
      end
      dmem_ack = 1'b1;
      dmem_rdata = v.rdata;
      tick();
      dmem_ack = 1'b0;
      dmem_rdata = 32'h0;
    end
    chk($sformatf("v%0d dmem_req low", idx), {31'b0, dmem_req}, 32'd0);
    chk($sformatf("v%0d out_valid", idx), {31'b0, out_valid}, 32'd1);
    if (v.chk_wb) chk($sformatf("v%0d wb_data", idx), wb_data, v.exp_wb);
    chk($sformatf("v%0d wb_reg", idx), {27'b0, wb_reg}, {27'b0, v.rg});
    chk($sformatf("v%0d wb_en", idx), {31'b0, wb_en}, {31'b0, v.exp_en});
    chk($sformatf("v%0d exc_misalign", idx), {31'b0, exc_misalign}, {31'b0, v.exp_exc});
    $display("vector %0d addr=%h wb_data=%h wb_en=%0d exc=%0d", idx, v.alu, wb_data, wb_en, exc_misalign);
    tick();
    chk($sformatf("v%0d drained", idx), {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    bit accepted;
    //           alu          rt           rd wr sz    sg rw rg     rdata         dly req we addr        be       wdata         wb            en exc chk
    vecs[0]  = '{32'h1234,    32'h0,       0, 0, 2'd2, 0, 1, 5'd5,  32'h0,        0,  0,  0, 32'h0,      4'h0,    32'h0,        32'h1234,     1, 0,  1};
    vecs[1]  = '{32'h103,     32'h0,       1, 0, 2'd0, 1, 1, 5'd8,  32'h000000F0, 2,  1,  0, 32'h100,    4'b0001, 32'h0,        32'hFFFFFFF0, 1, 0,  1};
    vecs[2]  = '{32'h202,     32'hABCD,    0, 1, 2'd1, 0, 0, 5'd0,  32'h0,        1,  1,  1, 32'h200,    4'b0011, 32'hABCDABCD, 32'h0,        0, 0,  0};
    vecs[3]  = '{32'h301,     32'h0,       1, 0, 2'd2, 0, 1, 5'd9,  32'h0,        0,  0,  0, 32'h0,      4'h0,    32'h0,        32'h0,        0, 1,  0};
    vecs[4]  = '{32'h101,     32'h0,       1, 0, 2'd0, 0, 1, 5'd10, 32'h12F45678, 1,  1,  0, 32'h100,    4'b0100, 32'h0,        32'h000000F4, 1, 0,  1};
    vecs[5]  = '{32'h200,     32'h0,       1, 0, 2'd1, 1, 1, 5'd11, 32'h8001FFFF, 0,  1,  0, 32'h200,    4'b1100, 32'h0,        32'hFFFF8001, 1, 0,  1};
    vecs[6]  = '{32'h100,     32'h5A,      0, 1, 2'd0, 0, 0, 5'd0,  32'h0,        0,  1,  1, 32'h100,    4'b1000, 32'h5A5A5A5A, 32'h0,        0, 0,  0};
    vecs[7]  = '{32'h404,     32'hCAFEF00D,0, 1, 2'd2, 0, 0, 5'd0,  32'h0,        3,  1,  1, 32'h404,    4'b1111, 32'hCAFEF00D, 32'h0,        0, 0,  0};
    vecs[8]  = '{32'h203,     32'h1,       0, 1, 2'd1, 0, 0, 5'd0,  32'h0,        0,  0,  0, 32'h0,      4'h0,    32'h0,        32'h0,        0, 1,  0};
    vecs[9]  = '{32'h8,       32'h0,       1, 0, 2'd3, 1, 1, 5'd12, 32'h87654321, 0,  1,  0, 32'h8,      4'b1111, 32'h0,        32'h87654321, 1, 0,  1};
    vecs[10] = '{32'h12,      32'h1122,    1, 1, 2'd1, 0, 1, 5'd13, 32'h0,        0,  1,  1, 32'h10,     4'b0011, 32'h11221122, 32'h0,        0, 0,  0};
    vecs[11] = '{32'h206,     32'h0,       1, 0, 2'd1, 1, 1, 5'd14, 32'h12347FFF, 0,  1,  0, 32'h204,    4'b0011, 32'h0,        32'h00007FFF, 1, 0,  1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive(32'h0, 32'h0, 0, 0, 2'd0, 0, 0, 5'd0);

    // Reset state
    tick();
    chk("rst in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst dmem_addr", dmem_addr, 32'h0);
    chk("rst dmem_be", {28'b0, dmem_be}, 32'h0);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst wb_data", wb_data, 32'h0);
    chk("rst wb_en", {31'b0, wb_en}, 32'd0);
    chk("rst exc", {31'b0, exc_misalign}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post-rst in_ready", {31'b0, in_ready}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Throughput: back-to-back pass-through ops while out_ready=1
    for (int i = 0; i < 3; i++) begin
      drive(32'h1000 + i, 32'h0, 0, 0, 2'd2, 0, 1, 5'(i + 1));
      in_valid = 1'b1;
      chk("b2b in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      chk("b2b out_valid", {31'b0, out_valid}, 32'd1);
      chk("b2b wb_data", wb_data, 32'h1000 + i);
      $display("back-to-back op %0d wb_data=%h", i, wb_data);
    end
    in_valid = 1'b0;
    tick();
    chk("b2b drained", {31'b0, out_valid}, 32'd0);

    // Backpressure on a word load
    out_ready = 1'b0;
    drive(32'h500, 32'h0, 1, 0, 2'd2, 0, 1, 5'd20);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp req", {31'b0, dmem_req}, 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk("bp out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp wb_data", wb_data, 32'hDEADBEEF);
      $display("backpressure cycle %0d wb_data=%h", i, wb_data);
      tick();
    end
    // Release and offer a new pass-through op; it must be taken within a few cycles.
    out_ready = 1'b1;
    drive(32'h77, 32'h0, 0, 0, 2'd2, 0, 1, 5'd21);
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 4 && !accepted; i++) begin
      accepted = in_ready;
      tick();
    end
    in_valid = 1'b0;
    chk("bp new accept", {31'b0, accepted}, 32'd1);
    chk("bp new out_valid", {31'b0, out_valid}, 32'd1);
    chk("bp new wb_data", wb_data, 32'h77);
    $display("after backpressure new op wb_data=%h", wb_data);
    tick();

    // Pass-through stalled by out_ready=0 keeps its record frozen
    out_ready = 1'b0;
    drive(32'h99, 32'h0, 0, 0, 2'd2, 0, 1, 5'd3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drive(32'h55, 32'h0, 0, 0, 2'd2, 0, 1, 5'd4);
    for (int i = 0; i < 2; i++) begin
      chk("pt stall in_ready", {31'b0, in_ready}, 32'd0);
      chk("pt stall wb_data", wb_data, 32'h99);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("pt stall drained", {31'b0, out_valid}, 32'd0);
    $display("stalled pass-through drained");

    // Reset pulsed while a request is outstanding
    drive(32'h600, 32'h0, 1, 0, 2'd2, 0, 1, 5'd7);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rreq req", {31'b0, dmem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rreq async drop", {31'b0, dmem_req}, 32'd0);
    tick();
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h13579BDF;
    tick();
    dmem_ack = 1'b0;
    chk("rreq late ack out_valid", {31'b0, out_valid}, 32'd0);
    chk("rreq late ack req", {31'b0, dmem_req}, 32'd0);
    tick();
    chk("rreq still idle", {31'b0, out_valid}, 32'd0);
    chk("rreq in_ready", {31'b0, in_ready}, 32'd1);
    $display("reset during request handled");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
